// File: rtl/cnn_pkg.sv
// cnn_pkg: shared conv-datapath states, default widths and ReLU helper
package cnn_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, ACC, OUT} acc_state_t;
  function automatic logic signed [DEF_WIDTH-1:0] relu_clamp(input logic signed [DEF_WIDTH-1:0] x);
    return x[DEF_WIDTH-1] ? '0 : x;
  endfunction
endpackage

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates cfg_len adder-tree sums plus bias, optional ReLU, valid/ready output
module psum_accumulator
  import cnn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_bias,
  input  logic             cfg_relu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  acc_state_t state, state_d;
  logic [WIDTH-1:0] acc, acc_d, out_q;
  logic [CNT_W-1:0] cnt, len_q, len_eff;
  logic relu_q, relu_d, beat, last;
  assign in_ready = state != OUT;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  assign out_data = out_q;
  assign beat = in_valid && in_ready;
  assign len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
  assign relu_d = (state == IDLE) ? cfg_relu : relu_q;
  always_comb begin
    acc_d = (state == IDLE) ? cfg_bias + in_data : acc + in_data;
    last = (state == IDLE) ? (len_eff == CNT_W'(1)) : (cnt + CNT_W'(1) == len_q);
    state_d = state;
    if (state == OUT) state_d = out_ready ? IDLE : OUT;
    else if (beat) state_d = last ? OUT : ACC;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      len_q <= '0;
      relu_q <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_d;
      if (beat) begin
        acc <= acc_d;
        cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
        if (state == IDLE) begin
          len_q <= len_eff;
          relu_q <= cfg_relu;
        end
        // result is captured once on the final beat so it stays put under backpressure
        if (last) out_q <= relu_d ? relu_clamp(acc_d) : acc_d;
      end
    end
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the 16-input combinational adder tree in the conv datapath.
- Accepts one signed tree sum per handshake and accumulates cfg_len consecutive sums for one output pixel; each sum covers one input-channel group.
- Adds a per-output bias, applies optional ReLU, and presents the result on a valid/ready output port.
- Single clock; one output pixel in flight at a time.

Parameters:
WIDTH, 32, data width of tree sums, bias, accumulator and result (two's complement)
CNT_W, 8, width of the beat counter and of cfg_len

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_len  input  CNT_W  number of tree sums per output; sampled on first accepted beat
cfg_bias  input  WIDTH  signed bias; sampled on first accepted beat
cfg_relu  input  1  1 = clamp negative results to 0; sampled on first accepted beat
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data
in_data  input  WIDTH  signed adder-tree sum
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  WIDTH  signed accumulated result
busy  output  1  high in ACC or OUT state

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; acc, cnt, len_q, relu_q = 0.
  - out_valid = 0, out_data = 0, in_ready = 1, busy = 0.
- Beat: an input beat is accepted when in_valid && in_ready on a rising clk.
- States: IDLE, ACC, OUT. in_ready = (state != OUT). out_valid = (state == OUT).
- IDLE, on an accepted beat:
  - acc <= cfg_bias + in_data; cnt <= 1; len_q <= (cfg_len == 0 ? 1 : cfg_len); relu_q <= cfg_relu.
  - If the effective len == 1, go to OUT; otherwise go to ACC.
- ACC, on an accepted beat:
  - acc <= acc + in_data; cnt <= cnt + 1.
  - If cnt + 1 == len_q, go to OUT.
  - No accepted beat: hold all state. Bubbles are allowed.
- OUT:
  - out_data = relu_q && acc[WIDTH-1] ? 0 : acc. It is registered and stable while out_valid && !out_ready.
  - On out_ready: go to IDLE. out_valid drops next cycle; in_ready rises next cycle. There is no same-cycle bypass.
- cfg_* changes while in ACC or OUT have no effect on the pixel in flight.
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Throughput: at best one result per len_q + 1 cycles.
- Arithmetic:
  - All additions are WIDTH-bit two's complement with silent wrap-around. No saturation and no widening, consistent with the adder tree.
  - The count range is 1 .. 2^CNT_W - 1. cfg_len = 0 is treated as 1.
- Reset asserted mid-operation: the partial accumulation is discarded. out_valid drops immediately (asynchronously) and no result is emitted.
- The block has no reaction to in_valid while in_ready is low. The upstream must hold in_data per the valid/ready rules.

Decomposition:
- Shared package cnn_pkg:
  - state enum (IDLE, ACC, OUT).
  - default WIDTH/CNT_W constants, shared with the adder tree.
  - relu_clamp function (signed WIDTH in, signed WIDTH out).
- No sub-module. The FSM, counter and accumulator live in one module. The ReLU clamp is the package function.

Test Plan:
- len=4, bias=10, relu=0, data 1,2,3,4 back-to-back -> out_valid one cycle after 4th beat, out_data=20, in_ready low until out_ready.
- len=3, bias=-100, relu=1, data 5,6,7 -> out_data=0; same stimulus with relu=0 -> out_data=-82.
- len=2, bias=0, data 7,8, out_ready held low 5 cycles -> out_data=15 stable all 5 cycles, in_ready=0 throughout; single handshake, then IDLE.
- cfg_len=0, bias=3, single beat data=4 -> treated as len 1, out_data=7; cfg_len changed to 9 during OUT -> no effect.
- Wrap: len=2, bias=0, data 0x7FFFFFFF, 1 -> out_data=0x80000000 (relu=0), 0 (relu=1).
- Reset mid-op: len=4, accept 2 beats, pulse rst_n low -> out_valid=0, busy=0. Then len=1, data=9, bias=0 -> out_data=9 with no residue.
